// File: rtl/matmul_pkg.sv
// Shared definitions for the N x N matrix multiplier: FSM encoding and
// width helpers used by the top and the MAC datapath.
package matmul_pkg;

  // Job phases: operand load, multiply-accumulate, result hand-off.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Full-precision result width: one product plus log2(N) bits of growth.
  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  // Index counter width; a 1x1 matrix still needs a one-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate unit with synchronous clear and enable.
// Build option MATMUL_SIGNED_EN selects two's-complement operands;
// without it operands are treated as unsigned.
module matmul_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] prod_ext;

`ifdef MATMUL_SIGNED_EN
  logic signed [2*DATA_W-1:0] prod;
  assign prod     = $signed(a) * $signed(b);
  // The cast of a signed product sign-extends into the accumulator width.
  assign prod_ext = ACC_W'(prod);
`else
  logic [2*DATA_W-1:0] prod;
  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);
`endif

  // Running sum including the current product; the top captures it on the last term.
  assign sum = acc_q + prod_ext;

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/matrix_multiplier_nxn.sv
// Handshaked N x N integer matrix multiplier. Operands stream in row-major,
// one A/B element pair per beat; C streams out row-major.
// Build option MATMUL_SIGNED_EN selects signed arithmetic (see matmul_mac).
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only while loading.
// out_valid, out_data and out_last hold steady until out_ready is seen;
// out_ready without out_valid does nothing.
module matrix_multiplier_nxn
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_width(N, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] a_mem [N][N];
  logic [DATA_W-1:0] b_mem [N][N];

  logic [IDX_W-1:0] lr, lc;   // load row/column
  logic [IDX_W-1:0] i, j, k;  // result row, result column, dot-product term

  logic load_fire, load_done, mac_en, mac_clr, mac_last, out_fire, last_elem;
  logic [ACC_W-1:0] mac_sum;

  assign load_done = (lr == LAST) && (lc == LAST);
  assign last_elem = (i == LAST) && (j == LAST);
  assign out_valid = (state == ST_OUT);

  // Next-state and control decode; every output defaulted first.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    load_fire = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_last  = 1'b0;
    out_fire  = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_fire = 1'b1;
          if (load_done) begin
            state_nx = ST_MAC;
            mac_clr  = 1'b1;
          end
        end
      end
      ST_MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (k == LAST) begin
          mac_last = 1'b1;
          state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        busy = 1'b1;
        if (out_ready) begin
          out_fire = 1'b1;
          if (last_elem) begin
            state_nx = ST_LOAD;
          end else begin
            state_nx = ST_MAC;
            mac_clr  = 1'b1;
          end
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  // Operand buffers: not reset, every entry is rewritten by each job.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_mem[lr][lc] <= a_in;
      b_mem[lr][lc] <= b_in;
    end
  end

  // Load position counters, row-major, wrapping back to 0 after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr <= '0;
      lc <= '0;
    end else if (load_fire) begin
      if (lc == LAST) begin
        lc <= '0;
        lr <= (lr == LAST) ? '0 : lr + 1'b1;
      end else begin
        lc <= lc + 1'b1;
      end
    end
  end

  // Dot-product term counter; wraps to 0 on the last term of each element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (mac_en) begin
      k <= (k == LAST) ? '0 : k + 1'b1;
    end
  end

  // Result position counters, advanced on each accepted output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (out_fire) begin
      if (j == LAST) begin
        j <= '0;
        i <= (i == LAST) ? '0 : i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  // Result register: captures the completed sum, held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_last <= 1'b0;
    end else if (mac_last) begin
      out_data <= mac_sum;
      out_last <= last_elem;
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_mem[i][k]),
    .b   (b_mem[k][j]),
    .sum (mac_sum)
  );

endmodule

// File: tb/tb_matrix_multiplier_nxn.sv
// Bench for matrix_multiplier_nxn: an N=2 and an N=3 instance share one
// stimulus bus, selected by sel. Honours MATMUL_SIGNED_EN for expectations.
module tb_matrix_multiplier_nxn;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic       sel;  // 0: N=2 instance, 1: N=3 instance
  logic       in_valid, out_ready;
  logic [7:0] a_in, b_in;

  logic        in_valid2, in_valid3;
  logic        in_ready2, in_ready3, out_valid2, out_valid3;
  logic        out_last2, out_last3, busy2, busy3;
  logic [16:0] o2;
  logic [17:0] o3;

  assign in_valid2 = in_valid & ~sel;
  assign in_valid3 = in_valid & sel;

  matrix_multiplier_nxn #(.N(2), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(o2), .out_last(out_last2), .busy(busy2)
  );

  matrix_multiplier_nxn #(.N(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(o3), .out_last(out_last3), .busy(busy3)
  );

  logic        cur_valid, cur_last, cur_in_ready, cur_busy;
  logic [17:0] cur_data;
  assign cur_valid    = sel ? out_valid3 : out_valid2;
  assign cur_last     = sel ? out_last3  : out_last2;
  assign cur_in_ready = sel ? in_ready3  : in_ready2;
  assign cur_busy     = sel ? busy3      : busy2;
  assign cur_data     = sel ? o3 : {1'b0, o2};

  // ---------------- scoreboard ----------------
  typedef struct {
    int n;
    int a[9];
    int b[9];
    int c[9];
  } vec_t;

  logic [18:0] exp_q[$];  // {last, data}
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [18:0] mk_exp(input int n, input int val, input bit last);
    logic [17:0] d;
    d = val[17:0];
    if (n == 2) d[17] = 1'b0;
    return {last, d};
  endfunction

  function automatic longint ext8(input int v);
    logic [7:0] t;
    t = v[7:0];
`ifdef MATMUL_SIGNED_EN
    return longint'($signed(t));
`else
    return longint'(t);
`endif
  endfunction

  // Reference product for randomised jobs.
  function automatic vec_t model_fill(input vec_t v);
    vec_t r;
    longint s;
    r = v;
    for (int ii = 0; ii < v.n; ii++)
      for (int jj = 0; jj < v.n; jj++) begin
        s = 0;
        for (int kk = 0; kk < v.n; kk++)
          s += ext8(v.a[ii*v.n+kk]) * ext8(v.b[kk*v.n+jj]);
        r.c[ii*v.n+jj] = int'(s);
      end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Entry/exit point of every task: just after a rising edge.
  task automatic load_job(input vec_t v);
    int nn;
    nn = v.n * v.n;
    sel = (v.n == 3);
    out_ready = 1'b0;
    for (int e = 0; e < nn; e++)
      exp_q.push_back(mk_exp(v.n, v.c[e], e == nn - 1));
    for (int e = 0; e < nn; e++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        a_in = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a_in = 8'(v.a[e]);
      b_in = 8'(v.b[e]);
      @(negedge clk);
      check("in_ready_load", cur_in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready high; 1: random; 2: low 5 cycles then high 1.
  task automatic collect(input int mode, input int budget);
    int cyc;
    logic held_v;
    logic [17:0] held_d;
    logic held_l;
    logic [18:0] e;
    cyc = 0;
    held_v = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    while (exp_q.size() > 0 && cyc < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 6 == 5);
      endcase
      @(negedge clk);
      if (held_v) begin
        check("hold_valid", cur_valid, 1);
        check("hold_data", cur_data, held_d);
        check("hold_last", cur_last, held_l);
      end
      held_v = 1'b0;
      if (cur_valid) begin
        check("in_ready_out", cur_in_ready, 0);
        check("busy_out", cur_busy, 1);
        if (out_ready) begin
          e = exp_q.pop_front();
          check("out_data", cur_data, e[17:0]);
          check("out_last", cur_last, e[18]);
        end else begin
          held_v = 1'b1;
          held_d = cur_data;
          held_l = cur_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("collect_timeout", exp_q.size(), 0);
    exp_q.delete();
    out_ready = 1'b0;
  endtask

  task automatic check_idle();
    @(negedge clk);
    check("idle_valid", cur_valid, 0);
    check("idle_in_ready", cur_in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input vec_t v, input int mode);
    load_job(v);
    collect(mode, 800);
    check_idle();
  endtask

  // ---------------- test ----------------
  vec_t vecs[5];

  initial begin
    vec_t rv;
    int lat;
    logic [18:0] e;

    vecs[0] = '{2, '{1,2,3,4,0,0,0,0,0}, '{5,6,7,8,0,0,0,0,0}, '{19,22,43,50,0,0,0,0,0}};
    vecs[2] = '{2, '{128,128,128,128,0,0,0,0,0}, '{128,128,128,128,0,0,0,0,0},
                '{32768,32768,32768,32768,0,0,0,0,0}};
`ifdef MATMUL_SIGNED_EN
    vecs[1] = '{3, '{255,255,255,255,255,255,255,255,255}, '{255,255,255,255,255,255,255,255,255},
                '{3,3,3,3,3,3,3,3,3}};
    vecs[3] = '{2, '{1,0,0,1,0,0,0,0,0}, '{255,2,3,252,0,0,0,0,0}, '{-1,2,3,-4,0,0,0,0,0}};
    vecs[4] = '{2, '{0,255,255,0,0,0,0,0,0}, '{255,1,0,255,0,0,0,0,0}, '{0,1,1,-1,0,0,0,0,0}};
`else
    vecs[1] = '{3, '{255,255,255,255,255,255,255,255,255}, '{255,255,255,255,255,255,255,255,255},
                '{195075,195075,195075,195075,195075,195075,195075,195075,195075}};
    vecs[3] = '{2, '{1,0,0,1,0,0,0,0,0}, '{255,2,3,252,0,0,0,0,0}, '{255,2,3,252,0,0,0,0,0}};
    vecs[4] = '{2, '{0,255,255,0,0,0,0,0,0}, '{255,1,0,255,0,0,0,0,0},
                '{0,65025,65025,255,0,0,0,0,0}};
`endif

    sel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready2, 1);
    check("rst_out_valid", out_valid2, 0);
    check("rst_out_last", out_last2, 0);
    check("rst_busy", busy2, 0);
    check("rst_out_data", o2, 0);
    check("rst_in_ready3", in_ready3, 1);
    check("rst_out_data3", o3, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: every vector under a different backpressure pattern.
    for (int v = 0; v < 5; v++) run_job(vecs[v], v % 3);

    // Latency: last beat accepted, then N MAC edges before out_valid.
    load_job(vecs[0]);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (cur_valid) break;
      check("busy_mac", cur_busy, 1);
      lat++;
      @(posedge clk); #1;
    end
    check("latency", lat, 2);
    @(posedge clk); #1;
    collect(0, 200);
    check_idle();

    // Backpressure: 5-cycle stalls on every element.
    rv.n = 2;
    for (int x = 0; x < 9; x++) begin
      rv.a[x] = $urandom_range(0, 255);
      rv.b[x] = $urandom_range(0, 255);
    end
    rv = model_fill(rv);
    run_job(rv, 2);

    // Reset during the second element's MAC phase.
    load_job(vecs[0]);
    out_ready = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (cur_valid) break;
      lat++;
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    check("pre_rst_data", cur_data, e[17:0]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", cur_busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid2, 0);
    check("mid_rst_in_ready", in_ready2, 1);
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_data", o2, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) check_idle();
    run_job(vecs[0], 0);

    // Back-to-back: in_valid held high with junk during the first job's output.
    load_job(vecs[4]);
    in_valid = 1'b1;
    a_in = 8'hAA;
    b_in = 8'h55;
    collect(1, 400);
    run_job(vecs[0], 1);

    // Random jobs on both sizes.
    for (int r = 0; r < 4; r++) begin
      rv.n = (r % 2 == 0) ? 2 : 3;
      for (int x = 0; x < 9; x++) begin
        rv.a[x] = $urandom_range(0, 255);
        rv.b[x] = $urandom_range(0, 255);
      end
      rv = model_fill(rv);
      run_job(rv, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
